// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: N_REQ requesters share one FIFO write port.
// An owner may burst up to MAX_BURST writes while others are waiting.
module fifo_wr_arb #(
  parameter int FIFO_WIDTH = 16,
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            req_ack,
  output logic [N_REQ-1:0]            req_err,
  output logic                        fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]       fifo_data_in,
  input  logic                        fifo_full,
  input  logic                        fifo_wr_ack,
  input  logic                        fifo_overflow,
  output logic                        busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] last_gnt_q, last_gnt_d;

  logic          found;
  logic [IW-1:0] pick;
  logic          keep;

  // First requester at or after ptr, wrapping around.
  always_comb begin : rr_search
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign keep = (state_q == BURST) && req[owner_q] && (cnt_q < CW'(MAX_BURST));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt     = '0;
    if (!rst && !fifo_full) begin
      if (keep) begin
        gnt[owner_q] = 1'b1;
        cnt_d        = cnt_q + CW'(1);
      end else if (found) begin
        gnt[pick] = 1'b1;
        state_d   = BURST;
        owner_d   = pick;
        cnt_d     = CW'(1);
        ptr_d     = (pick == IW'(N_REQ - 1)) ? '0 : pick + IW'(1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  assign last_gnt_d = gnt;

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) fifo_data_in = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  assign fifo_wr_en = |gnt;
  assign req_ack    = (rst || !fifo_wr_ack)   ? '0 : last_gnt_q;
  assign req_err    = (rst || !fifo_overflow) ? '0 : last_gnt_q;
  assign busy       = !rst && (state_q == BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      last_gnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a behavioural arbiter model.
module tb_fifo_wr_arb;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int MB = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt, req_ack, req_err;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_full, fifo_wr_ack, fifo_overflow;
  logic           busy;

  fifo_wr_arb #(.FIFO_WIDTH(W), .N_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .req_ack(req_ack), .req_err(req_err),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack),
    .fifo_overflow(fifo_overflow), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // model state: who owns the port, how many writes so far, where the search starts
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_cnt   = 0;
  int m_ptr   = 0;
  // scoreboard: grant vector of the previous cycle, consumed by ack/err checks
  logic [N-1:0] exp_q[$];

  logic [N-1:0] s_gnt, s_ack, s_err;
  logic         s_wr_en, s_busy;
  logic [W-1:0] s_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver + compare: apply one cycle of inputs, check outputs mid-cycle, advance model
  task automatic step(input logic [N-1:0] r, input logic f, input logic a,
                      input logic o, input logic rs);
    int pick;
    bit cont;
    logic [N-1:0] eg, el, one;
    logic [W-1:0] ed;
    one = 1;
    req = r; fifo_full = f; fifo_wr_ack = a; fifo_overflow = o; rst = rs;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    @(negedge clk);
    pick = -1;
    cont = 1'b0;
    if (!rs && !f) begin
      if (m_busy && r[m_owner] && m_cnt < MB) begin
        pick = m_owner;
        cont = 1'b1;
      end else begin
        for (int k = 0; k < N; k++)
          if (pick < 0 && r[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      end
    end
    eg = (pick >= 0) ? (one << pick) : '0;
    ed = (pick >= 0) ? req_data[pick*W +: W] : '0;
    el = exp_q.pop_front();
    s_gnt = gnt; s_ack = req_ack; s_err = req_err;
    s_wr_en = fifo_wr_en; s_busy = busy; s_data = fifo_data_in;
    chk("gnt", s_gnt, eg);
    chk("wr_en", s_wr_en, (pick >= 0));
    chk("data", s_data, ed);
    chk("ack", s_ack, (rs || !a) ? '0 : el);
    chk("err", s_err, (rs || !o) ? '0 : el);
    chk("busy", s_busy, !rs && m_busy);
    exp_q.push_back(rs ? '0 : eg);
    if (rs) begin
      m_busy = 1'b0; m_cnt = 0; m_ptr = 0;
    end else if (!f) begin
      if (pick < 0) begin
        m_busy = 1'b0; m_cnt = 0;
      end else if (cont) begin
        m_cnt++;
      end else begin
        m_busy = 1'b1; m_owner = pick; m_cnt = 1; m_ptr = (pick + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] one;
    one = 1;
    exp_q.push_back('0);

    // reset with all requests high
    step(4'b1111, 1'b0, 1'b1, 1'b1, 1'b1);
    step(4'b1111, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_gnt", s_gnt, 0);
    chk("rst_ack", s_ack, 0);
    chk("rst_busy", s_busy, 0);

    // all requesting: four-write bursts rotating 0,1,2
    for (int k = 0; k < 12; k++) begin
      step(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("rr_gnt", s_gnt, one << (k / 4));
      chk("rr_ack", s_ack, (k == 0) ? '0 : (one << ((k - 1) / 4)));
    end

    // lone requester: no bubble at the burst boundary
    for (int k = 0; k < 6; k++) begin
      step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("solo_gnt", s_gnt, 4'b0001);
    end

    // owner drops: same-cycle handover
    step(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_gnt0", s_gnt, 4'b0001);
    step(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_gnt1", s_gnt, 4'b0010);

    // overflow response to requester 1's write
    step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_err", s_err, 4'b0010);
    chk("ovf_ack", s_ack, 4'b0000);
    chk("ovf_gnt", s_gnt, 4'b0000);
    step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_err_once", s_err, 4'b0000);

    // full stall mid-burst of requester 2
    step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_pre1", s_gnt, 4'b0100);
    step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_pre2", s_gnt, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      step(4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("full_gnt", s_gnt, 4'b0000);
      chk("full_wr_en", s_wr_en, 1'b0);
    end
    step(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_post1", s_gnt, 4'b0100);
    step(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_post2", s_gnt, 4'b0100);
    step(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_next", s_gnt, 4'b1000);

    // reset in the middle of requester 3's burst
    step(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_gnt", s_gnt, 4'b1000);
    for (int k = 0; k < 2; k++) begin
      step(4'b1000, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("mid_rst_gnt", s_gnt, 4'b0000);
      chk("mid_rst_data", s_data, 0);
      chk("mid_rst_ack", s_ack, 4'b0000);
      chk("mid_rst_busy", s_busy, 1'b0);
    end
    step(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_gnt", s_gnt, 4'b1000);
    chk("post_rst_busy", s_busy, 1'b0);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      step(N'($urandom_range(0, 15)),
           ($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 80) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
